// File: rtl/pipe_ctrl_if.sv
// Stall/flush bundle between the pipeline stages and the central controller.
// The controller connects through the slave modport; the core side uses master.
// Signal names keep the controller's _i/_o view so both ends read the same.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_if_i;
    logic             stallreq_id_i;
    logic             stallreq_ex_i;
    logic             stallreq_mem_i;
    logic [31:0]      excepttype_i;
    logic [31:0]      cp0_epc_i;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             stall_timeout_o;

    // Core side: raises stall requests and exceptions, consumes stall/flush.
    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output excepttype_i, cp0_epc_i,
        input  stall_o, flush_o, new_pc_o, stall_cnt_o, stall_timeout_o
    );

    // Controller side.
    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  excepttype_i, cp0_epc_i,
        output stall_o, flush_o, new_pc_o, stall_cnt_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences exception flushes, tracks stalls.
// Latency: stall/flush/new_pc are combinational (same cycle); counters and watchdog update next edge.
// Backpressure: a pending flush is deferred while the fetch side stalls, freezing the whole pipe.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
    parameter int          TIMEOUT    = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        WAIT_IF = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [TW-1:0]    consec_q, consec_d;
    logic             timeout_q, timeout_d;

    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [31:0]      target;
    logic             exc_vld;

    assign exc_vld = (bus.excepttype_i != 32'd0);
    assign target  = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;

    // State, pending redirect and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pend_pc_q   <= 32'd0;
            stall_cnt_q <= '0;
            consec_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_pc_q   <= pend_pc_d;
            stall_cnt_q <= stall_cnt_d;
            consec_q    <= consec_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state and stall/flush outputs; everything is held low during reset.
    always_comb begin
        stall     = 6'b000000;
        flush     = 1'b0;
        new_pc    = 32'd0;
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (exc_vld) begin
                        if (bus.stallreq_if_i) begin
                            // Fetch is mid-transaction: freeze everything and
                            // remember where to go once it completes.
                            stall     = 6'b111111;
                            pend_pc_d = target;
                            state_d   = WAIT_IF;
                        end else begin
                            flush  = 1'b1;
                            new_pc = target;
                        end
                    end else if (bus.stallreq_mem_i) begin
                        stall = 6'b011111;
                    end else if (bus.stallreq_ex_i) begin
                        stall = 6'b001111;
                    end else if (bus.stallreq_id_i) begin
                        stall = 6'b000111;
                    end else if (bus.stallreq_if_i) begin
                        stall = 6'b000011;
                    end
                end
                WAIT_IF: begin
                    // The frozen pipe keeps the MEM exception in place, so the
                    // live excepttype is not consulted here.
                    if (bus.stallreq_if_i) begin
                        stall = 6'b111111;
                    end else begin
                        flush   = 1'b1;
                        new_pc  = pend_pc_q;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating stall counter and the sticky consecutive-stall watchdog.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        consec_d    = consec_q;
        timeout_d   = timeout_q;
        if (stall[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (stall == 6'b000000) begin
            consec_d = '0;
        end else if (consec_q != TIMEOUT_V) begin
            consec_d = consec_q + TW'(1);
        end
        if (consec_d == TIMEOUT_V) begin
            timeout_d = 1'b1;
        end
    end

    assign bus.stall_o         = stall;
    assign bus.flush_o         = flush;
    assign bus.new_pc_o        = new_pc;
    assign bus.stall_cnt_o     = stall_cnt_q;
    assign bus.stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with TIMEOUT shortened to 8.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
// Expected values are hand-computed constants per step.
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    pipe_ctrl_if #(.CNT_W(32)) bus ();

    pipe_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .ERET_CODE  (32'h0000_000e),
        .TIMEOUT    (8),
        .CNT_W      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock, leaving time just past the edge for input changes.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s_if, input logic s_id, input logic s_ex, input logic s_mem,
                         input logic [31:0] exc, input logic [31:0] epc);
        bus.stallreq_if_i  = s_if;
        bus.stallreq_id_i  = s_id;
        bus.stallreq_ex_i  = s_ex;
        bus.stallreq_mem_i = s_mem;
        bus.excepttype_i   = exc;
        bus.cp0_epc_i      = epc;
    endtask

    task automatic look(input string tag, input logic [5:0] e_stall, input logic e_flush,
                        input logic [31:0] e_pc);
        @(negedge clk);
        chk({tag, ".stall"}, {26'd0, bus.stall_o}, {26'd0, e_stall});
        chk({tag, ".flush"}, {31'd0, bus.flush_o}, {31'd0, e_flush});
        chk({tag, ".new_pc"}, bus.new_pc_o, e_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        cyc();
        cyc();
        // Reset forces outputs low even with a stall request present.
        look("reset", 6'b000000, 1'b0, 32'd0);
        chk("reset.cnt", bus.stall_cnt_o, 32'd0);
        chk("reset.timeout", {31'd0, bus.stall_timeout_o}, 32'd0);
        cyc();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        look("idle", 6'b000000, 1'b0, 32'd0);

        // 1: stall priority encoding and stall counting.
        cyc(); drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        look("t1.id", 6'b000111, 1'b0, 32'd0);
        cyc(); drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
        look("t1.mem", 6'b011111, 1'b0, 32'd0);
        chk("t1.cnt1", bus.stall_cnt_o, 32'd1);
        cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        look("t1.rel", 6'b000000, 1'b0, 32'd0);
        chk("t1.cnt2", bus.stall_cnt_o, 32'd2);
        cyc(); drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        look("t1.ex", 6'b001111, 1'b0, 32'd0);
        cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        look("t1.if", 6'b000011, 1'b0, 32'd0);
        cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        look("t1.rel2", 6'b000000, 1'b0, 32'd0);
        chk("t1.cnt4", bus.stall_cnt_o, 32'd4);

        // 2: exception overrides an EX stall, redirects to the vector.
        cyc(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h1234_0000);
        look("t2.exc", 6'b000000, 1'b1, 32'h0000_0020);
        cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        look("t2.after", 6'b000000, 1'b0, 32'd0);
        chk("t2.cnt", bus.stall_cnt_o, 32'd4);

        // 3: ERET redirects to EPC.
        cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000e, 32'hBFC0_0100);
        look("t3.eret", 6'b000000, 1'b1, 32'hBFC0_0100);

        // 4: exception deferred behind a fetch stall for three cycles.
        cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 32'hBFC0_0100);
        look("t4.c1", 6'b111111, 1'b0, 32'd0);
        cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000e, 32'h1234_5678);
        look("t4.c2", 6'b111111, 1'b0, 32'd0);
        cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1234_5678);
        look("t4.c3", 6'b111111, 1'b0, 32'd0);
        cyc(); drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_000e, 32'h1234_5678);
        look("t4.flush", 6'b000000, 1'b1, 32'h0000_0020);
        chk("t4.cnt", bus.stall_cnt_o, 32'd7);
        cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000e, 32'h8000_0180);
        look("t4.run", 6'b000000, 1'b1, 32'h8000_0180);
        cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        look("t4.quiet", 6'b000000, 1'b0, 32'd0);

        // 5: watchdog needs TIMEOUT consecutive stalled cycles and is sticky.
        cyc(); drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 7; i++) cyc();
        @(negedge clk);
        chk("t5.seven", {31'd0, bus.stall_timeout_o}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        @(negedge clk);
        chk("t5.gap", {31'd0, bus.stall_timeout_o}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 7; i++) cyc();
        @(negedge clk);
        chk("t5.seven_b", {31'd0, bus.stall_timeout_o}, 32'd0);
        cyc();
        @(negedge clk);
        chk("t5.eight", {31'd0, bus.stall_timeout_o}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        cyc();
        @(negedge clk);
        chk("t5.sticky", {31'd0, bus.stall_timeout_o}, 32'd1);
        chk("t5.cnt", bus.stall_cnt_o, 32'd22);

        // 6: reset while waiting on fetch drops the pending redirect.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 32'd0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        look("t6.wait", 6'b111111, 1'b0, 32'd0);
        rst = 1'b1;
        look("t6.rst", 6'b000000, 1'b0, 32'd0);
        cyc();
        @(negedge clk);
        chk("t6.cnt", bus.stall_cnt_o, 32'd0);
        chk("t6.timeout", {31'd0, bus.stall_timeout_o}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        look("t6.post", 6'b000000, 1'b0, 32'd0);
        cyc();
        look("t6.post2", 6'b000000, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core.
- Merges stall requests from IF, ID, EX and MEM into the 6-bit per-stage stall vector consumed by the pc register and every inter-stage register (if/id, id/ex, ex/mem, mem/wb).
- Sequences exception/ERET flushes and the redirect PC. Defers a flush while the fetch side is mid-transaction.
- Keeps a saturating stall-cycle counter and a sticky watchdog for stuck stalls.

Parameters:
EXC_VECTOR, 32'h00000020, redirect target for every non-ERET exception
ERET_CODE, 32'h0000000e, excepttype_i value meaning ERET (redirect to cp0_epc_i)
TIMEOUT, 1024, consecutive stalled cycles that set stall_timeout_o (must be >= 2)
CNT_W, 32, width of stall_cnt_o

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
stallreq_if_i  input  1  fetch side busy (icache/bus), 1 = request stall
stallreq_id_i  input  1  decode hazard (load-use), 1 = request stall
stallreq_ex_i  input  1  multi-cycle EX op (mul/div), 1 = request stall
stallreq_mem_i  input  1  data memory wait, 1 = request stall
excepttype_i  input  32  exception code from MEM stage; 0 = none
cp0_epc_i  input  32  current EPC from CP0
stall_o  output  6  per-stage stall: bit0 pc, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold
flush_o  output  1  clear all pipeline registers this cycle
new_pc_o  output  32  redirect PC, valid only when flush_o = 1, else 0
stall_cnt_o  output  CNT_W  cycles with stall_o[0] = 1, saturating
stall_timeout_o  output  1  sticky: stall persisted >= TIMEOUT cycles

Behaviour:
- Reset (rst = 1 at a clock edge):
  - State <- RUN; pend_pc <- 0; stall_cnt_o <- 0; consecutive counter <- 0; stall_timeout_o <- 0.
  - While rst is high, stall_o, flush_o and new_pc_o are forced to 0 combinationally.
- stall_o, flush_o and new_pc_o are combinational from inputs and state (same-cycle effect at the next posedge of the stage registers). All counters and state are registered.
- Exception target = cp0_epc_i if excepttype_i == ERET_CODE, else EXC_VECTOR.
- Stall priority in RUN with no exception, highest first:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
  - Each pattern stalls the requesting stage and everything upstream. Downstream keeps flowing; the register just past the stall boundary inserts a bubble.
- FSM, state RUN:
  - excepttype_i != 0 and stallreq_if_i == 0: flush_o = 1, new_pc_o = target, stall_o = 0. Stay in RUN.
  - excepttype_i != 0 and stallreq_if_i == 1: flush_o = 0, stall_o = 6'b111111, pend_pc <- target. Next state is WAIT_IF.
  - excepttype_i == 0: priority stall encoding above, flush_o = 0.
- FSM, state WAIT_IF:
  - excepttype_i is ignored (the whole pipe is frozen, so the MEM exception is held anyway).
  - stallreq_if_i == 1: stall_o = 6'b111111, flush_o = 0.
  - stallreq_if_i == 0: flush_o = 1, new_pc_o = pend_pc, stall_o = 0. Next state is RUN.
- Flush overrides all stall requests in the same cycle. new_pc_o is 0 whenever flush_o = 0.
- stall_cnt_o increments when stall_o[0] == 1 and holds at all-ones (no wrap).
- Watchdog:
  - Consecutive counter increments while stall_o != 0 and clears to 0 when stall_o == 0. It saturates at TIMEOUT.
  - On the edge where the counter reaches TIMEOUT, stall_timeout_o <- 1. It stays set until rst; it is not cleared by a stall ending.
- Reset mid-WAIT_IF: pending redirect is discarded, no flush is issued.

Test Plan:
1. stallreq_id_i = 1 only -> stall_o = 6'b000111. Raise stallreq_mem_i the same cycle -> stall_o = 6'b011111. Release all -> stall_o = 0; stall_cnt_o counted 1 per stalled cycle.
2. excepttype_i = 32'h00000001, stallreq_ex_i = 1 -> same cycle flush_o = 1, new_pc_o = 32'h00000020, stall_o = 0; next cycle flush_o = 0.
3. excepttype_i = 32'h0000000e, cp0_epc_i = 32'hBFC00100 -> flush_o = 1, new_pc_o = 32'hBFC00100.
4. Exception with stallreq_if_i = 1 held 3 cycles:
   - during those 3 cycles stall_o = 6'b111111, flush_o = 0;
   - on the cycle stallreq_if_i drops: flush_o = 1, new_pc_o = latched target, even if excepttype_i and cp0_epc_i have changed;
   - then back in RUN.
5. With TIMEOUT = 8, hold stallreq_mem_i 7 cycles, release 1 cycle, then hold 8 cycles -> stall_timeout_o stays 0 after the first 7, goes to 1 after the 8th consecutive stalled cycle, and stays 1 after release.
6. Assert rst while in WAIT_IF -> stall_o = 0, flush_o = 0, counters = 0, stall_timeout_o = 0. After rst deasserts with stallreq_if_i = 0, no flush occurs.
